decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 No parameters; datapath width fixed at 32 bits, register file 32 x 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; asserted when low.
REQ-004 instrD  input  32  instruction from fetch pipeline register.
REQ-005 PCD  input  32  PC of instrD.
REQ-006 FlushE  input  1  replace next ID/EX contents with bubble.
REQ-007 RegWriteW, RdW[4:0], ResultW[31:0]  inputs  write-back port.
REQ-008 RD1E, RD2E, ImmExtE, PCE  outputs  32 each  ID/EX data registers.
REQ-009 Rs1E, Rs2E, RdE  outputs  5 each  register indices for hazard unit.
REQ-010 RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  outputs  1 each  control.
REQ-011 ResultSrcE[1:0], ALUControlE[2:0]  outputs  control.

Function
REQ-012 Decode supported opcodes: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, JAL 1101111.
REQ-013 Unsupported opcode, including all-zero instrD (fetch bubble), decodes to all-zero control (NOP).
REQ-014 Immediate: I sign-extended [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}; R and unsupported give 0.
REQ-015 ALUControl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt; load/store/JAL use add, branch uses sub, funct7[5]=1 selects sub only for R-type.
REQ-016 ResultSrc: 00 ALU, 01 memory (load), 10 PC+4 (JAL).
REQ-017 Register file: combinational reads at instrD[19:15], [24:20]; synchronous write on clk rising edge when RegWriteW=1 and RdW!=0.
REQ-018 x0 reads as 0 always; writes to x0 discarded.
REQ-019 Latency: one cycle; all E outputs registered, decoded from instrD of previous cycle.
REQ-020 FlushE=1 at clock edge: all control E outputs and RdE, Rs1E, Rs2E load 0; data registers load 0.
REQ-021 FlushE has no effect on register-file writes of the same cycle.

Reset
REQ-022 rst low asynchronously clears every ID/EX register and every output to 0.
REQ-023 rst low clears all 32 registers to 0; writes ignored while reset held.
REQ-024 First edge after rst deassertion captures decode of current instrD normally.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN.
REQ-026 Defined: a read whose index equals RdW (nonzero) while RegWriteW=1 returns ResultW in the same cycle (write-through).
REQ-027 Undefined: the read returns the old register value; the hazard unit must cover the WB-to-ID case with a stall.

Verification
REQ-028 instrD=0x00500093 (addi x1,x0,5) -> next cycle ImmExtE=5, RdE=1, RegWriteE=1, ALUSrcE=1, ALUControlE=000.
REQ-029 Write x1=0x10 via WB; then instrD=0x0020A423 (sw x2,8(x1)) -> RD1E=0x10, ImmExtE=8, MemWriteE=1, RegWriteE=0.
REQ-030 beq with imm -4 -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=001.
REQ-031 RegWriteW=1, RdW=0, ResultW=0xDEAD, then read x0 -> RD1E=0.
REQ-032 Same-cycle WB to x3=0x55 and read x3 -> RD1E=0x55 with REGFILE_BYPASS_EN, old value without.
REQ-033 FlushE=1 with valid addi, then rst pulse low mid-run -> all E outputs 0 immediately; instrD=0 -> all control 0.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage of a 5-stage RV32I-subset pipeline: control decode, immediate
// generation, 32x32 register file and the ID/EX pipeline register.
// Optional macro REGFILE_BYPASS_EN adds write-through from the WB port to the read ports.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic [31:0] PCD,
    input  logic        FlushE,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic        BranchE,
    output logic        JumpE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_sel_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        alu_op_t     alu_control;
    } ctrl_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    ctrl_t       ctrl_d;
    ctrl_t       ctrl_e;
    imm_sel_t    imm_sel;
    logic [31:0] imm_ext;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] regs [32];

    assign opcode = instrD[6:0];
    assign funct3 = instrD[14:12];
    assign rs1    = instrD[19:15];
    assign rs2    = instrD[24:20];
    assign rd     = instrD[11:7];

    // The funct7 subtract bit is only meaningful for R-type; I-ALU passes 0.
    function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        ctrl_d  = '0;
        imm_sel = IMM_NONE;
        case (opcode)
            OP_R: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_control = alu_from_funct(funct3, instrD[30]);
            end
            OP_I: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = alu_from_funct(funct3, 1'b0);
                imm_sel            = IMM_I;
            end
            OP_LOAD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = RES_MEM;
                imm_sel           = IMM_I;
            end
            OP_STORE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_sel          = IMM_S;
            end
            OP_BRANCH: begin
                ctrl_d.branch      = 1'b1;
                ctrl_d.alu_control = ALU_SUB;
                imm_sel            = IMM_B;
            end
            OP_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.result_src = RES_PC4;
                imm_sel           = IMM_J;
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_ext = '0;
        case (imm_sel)
            IMM_I:   imm_ext = {{20{instrD[31]}}, instrD[31:20]};
            IMM_S:   imm_ext = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            IMM_B:   imm_ext = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
            IMM_J:   imm_ext = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    always_comb begin
        rd1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
        rd2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
`ifdef REGFILE_BYPASS_EN
        if (RegWriteW && (RdW != 5'd0) && (RdW == rs1)) rd1 = ResultW;
        if (RegWriteW && (RdW != 5'd0) && (RdW == rs2)) rd2 = ResultW;
`endif
    end

    // NOTE: the register file is a flop array, not an SRAM, so it can and must
    // be cleared by reset; x0 is never written and also masked on read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (RegWriteW && (RdW != 5'd0)) begin
            regs[RdW] <= ResultW;
        end
    end

    // NOTE: non-blocking assignments here so every ID/EX register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_e  <= '0;
            RD1E    <= '0;
            RD2E    <= '0;
            ImmExtE <= '0;
            PCE     <= '0;
            Rs1E    <= '0;
            Rs2E    <= '0;
            RdE     <= '0;
        end else if (FlushE) begin
            ctrl_e  <= '0;
            RD1E    <= '0;
            RD2E    <= '0;
            ImmExtE <= '0;
            PCE     <= '0;
            Rs1E    <= '0;
            Rs2E    <= '0;
            RdE     <= '0;
        end else begin
            ctrl_e  <= ctrl_d;
            RD1E    <= rd1;
            RD2E    <= rd2;
            ImmExtE <= imm_ext;
            PCE     <= PCD;
            Rs1E    <= rs1;
            Rs2E    <= rs2;
            RdE     <= rd;
        end
    end

    assign RegWriteE   = ctrl_e.reg_write;
    assign ResultSrcE  = ctrl_e.result_src;
    assign MemWriteE   = ctrl_e.mem_write;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign BranchE     = ctrl_e.branch;
    assign JumpE       = ctrl_e.jump;
    assign ALUControlE = ctrl_e.alu_control;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expected values are hand-decoded
// from the instruction encodings. Build with +define+REGFILE_BYPASS_EN to test write-through.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic        FlushE;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [9:0]  ctrl_obs;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .instrD(instrD), .PCD(PCD), .FlushE(FlushE),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE)
    );

    assign ctrl_obs = {RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, BranchE, JumpE, ALUControlE};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] mk_ctrl(input logic rw, input logic [1:0] rs, input logic mw,
                                           input logic as, input logic br, input logic j,
                                           input logic [2:0] alu);
        return {rw, rs, mw, as, br, j, alu};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl"}, {22'd0, ctrl_obs}, 32'd0);
        check({tag, " RD1E"}, RD1E, 32'd0);
        check({tag, " RD2E"}, RD2E, 32'd0);
        check({tag, " ImmExtE"}, ImmExtE, 32'd0);
        check({tag, " PCE"}, PCE, 32'd0);
        check({tag, " regidx"}, {17'd0, Rs1E, Rs2E, RdE}, 32'd0);
    endtask

    logic [31:0] x3_same_cycle_exp;

    initial begin
        rst = 1'b1; instrD = '0; PCD = '0; FlushE = 1'b0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        #2 rst = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // addi x1,x0,5
        instrD = 32'h00500093; PCD = 32'h100;
        cyc();
        check("addi ImmExtE", ImmExtE, 32'd5);
        check("addi RdE", {27'd0, RdE}, 32'd1);
        check("addi ctrl", {22'd0, ctrl_obs}, {22'd0, mk_ctrl(1, 2'b00, 0, 1, 0, 0, 3'b000)});
        check("addi PCE", PCE, 32'h100);

        // WB x1=0x10, then sw x2,8(x1)
        instrD = 32'h0; RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h10;
        cyc();
        RegWriteW = 1'b0;
        instrD = 32'h0020A423; PCD = 32'h104;
        cyc();
        check("sw RD1E", RD1E, 32'h10);
        check("sw RD2E", RD2E, 32'h0);
        check("sw ImmExtE", ImmExtE, 32'd8);
        check("sw ctrl", {22'd0, ctrl_obs}, {22'd0, mk_ctrl(0, 2'b00, 1, 1, 0, 0, 3'b000)});
        check("sw Rs1E/Rs2E", {22'd0, Rs1E, Rs2E}, {22'd0, 5'd1, 5'd2});

        // beq x1,x2,-4
        instrD = 32'hFE208EE3;
        cyc();
        check("beq ImmExtE", ImmExtE, 32'hFFFFFFFC);
        check("beq ctrl", {22'd0, ctrl_obs}, {22'd0, mk_ctrl(0, 2'b00, 0, 0, 1, 0, 3'b001)});

        // Write to x0 is discarded, both in the same cycle and afterwards
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hDEAD;
        instrD = 32'h00500093;
        cyc();
        check("x0 same-cycle RD1E", RD1E, 32'd0);
        RegWriteW = 1'b0;
        cyc();
        check("x0 later RD1E", RD1E, 32'd0);

        // x3=0x22, then same-cycle WB x3=0x55 while reading x3 (addi x4,x3,0)
        instrD = 32'h0; RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h22;
        cyc();
        ResultW = 32'h55; instrD = 32'h00018213;
`ifdef REGFILE_BYPASS_EN
        x3_same_cycle_exp = 32'h55;
`else
        x3_same_cycle_exp = 32'h22;
`endif
        cyc();
        check("x3 same-cycle RD1E", RD1E, x3_same_cycle_exp);
        RegWriteW = 1'b0;
        cyc();
        check("x3 next-cycle RD1E", RD1E, 32'h55);

        // sub x5,x1,x3
        instrD = 32'h403082B3;
        cyc();
        check("sub ctrl", {22'd0, ctrl_obs}, {22'd0, mk_ctrl(1, 2'b00, 0, 0, 0, 0, 3'b001)});
        check("sub RD1E", RD1E, 32'h10);
        check("sub RD2E", RD2E, 32'h55);
        check("sub ImmExtE", ImmExtE, 32'd0);

        // addi x1,x0,0x400: instr[30] set but I-type must stay add
        instrD = 32'h40000093;
        cyc();
        check("addi bit30 ctrl", {22'd0, ctrl_obs}, {22'd0, mk_ctrl(1, 2'b00, 0, 1, 0, 0, 3'b000)});
        check("addi bit30 ImmExtE", ImmExtE, 32'h400);

        // lw x6,-1(x1)
        instrD = 32'hFFF0A303;
        cyc();
        check("lw ImmExtE", ImmExtE, 32'hFFFFFFFF);
        check("lw ctrl", {22'd0, ctrl_obs}, {22'd0, mk_ctrl(1, 2'b01, 0, 1, 0, 0, 3'b000)});

        // jal x1,8
        instrD = 32'h008000EF;
        cyc();
        check("jal ImmExtE", ImmExtE, 32'd8);
        check("jal ctrl", {22'd0, ctrl_obs}, {22'd0, mk_ctrl(1, 2'b10, 0, 0, 0, 1, 3'b000)});

        // lui is unsupported here -> NOP
        instrD = 32'h12345037;
        cyc();
        check("unsupported ctrl", {22'd0, ctrl_obs}, 32'd0);
        check("unsupported ImmExtE", ImmExtE, 32'd0);

        // Flush with a valid addi; the concurrent WB to x9 must still land
        instrD = 32'h00500093; PCD = 32'h200; FlushE = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h99;
        cyc();
        check_all_zero("flush");
        FlushE = 1'b0; RegWriteW = 1'b0;
        instrD = 32'h00048393;
        cyc();
        check("flush wb x9 RD1E", RD1E, 32'h99);
        check("post-flush PCE", PCE, 32'h200);

        // Asynchronous reset mid-cycle, with a write attempt while held
        rst = 1'b0;
        #1 check_all_zero("async reset");
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h77;
        cyc();
        RegWriteW = 1'b0;
        rst = 1'b1;
        instrD = 32'h00018393;
        cyc();
        check("post-reset x3 RD1E", RD1E, 32'd0);
        check("post-reset ctrl", {22'd0, ctrl_obs}, {22'd0, mk_ctrl(1, 2'b00, 0, 1, 0, 0, 3'b000)});
        instrD = 32'h0;
        cyc();
        check("bubble ctrl", {22'd0, ctrl_obs}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
